// File: rtl/mips_mult_wb.sv
// Shift-add 32x32 unsigned multiplier feeding the regfile write port.
// Define MULT_HI_WB_EN to also write the high word to dst+1.
module mips_mult_wb #(
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  dest_regnum,
  output logic        busy,
  output logic        done,
  output logic [4:0]  wr_regnum,
  output logic [31:0] wr_data,
  output logic        writeenable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
`ifdef MULT_HI_WB_EN
    WB_LO = 2'd2,
    WB_HI = 2'd3
`else
    WB_LO = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [4:0]  dst_q, dst_d;
  logic [4:0]  count_q, count_d;
  logic [32:0] sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dst_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dst_q    <= dst_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dst_d    = dst_q;
    count_d  = count_q;
    sum      = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);

    busy        = (state_q != IDLE);
    done        = 1'b0;
    writeenable = 1'b0;
    wr_regnum   = '0;
    wr_data     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = rs_data;
          acc_lo_d = rt_data;
          acc_hi_d = '0;
          dst_d    = dest_regnum;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // 65-bit right shift of {carry, acc_hi, acc_lo}
        {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = WB_LO;
      end
      WB_LO: begin
        wr_regnum   = dst_q;
        wr_data     = acc_lo_q;
        writeenable = !(ZERO_REG_PROTECT && dst_q == 5'd0);
`ifdef MULT_HI_WB_EN
        state_d     = WB_HI;
`else
        done        = 1'b1;
        state_d     = IDLE;
`endif
      end
`ifdef MULT_HI_WB_EN
      WB_HI: begin
        wr_regnum   = dst_q + 5'd1;
        wr_data     = acc_hi_q;
        writeenable = !(ZERO_REG_PROTECT
                        && dst_q == 5'd31);
        done        = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule
